muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, alongside the ALU.
- Consumes the R-type funct codes that the ALU decoder maps to `ALU_XXX`: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- Owns the architectural HI/LO registers.
- Raises busy so hazard logic can stall any MFHI/MFLO/MULT/DIV issued while an operation is in flight.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  instruction valid in execute stage, with funct
- funct  in  6  R-type funct field. Codes: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
- rs_val  in  WIDTH  operand A (dividend / multiplicand / MTHI-MTLO source)
- rt_val  in  WIDTH  operand B (divisor / multiplier)
- busy  out  1  operation in flight; new starts ignored
- done  out  1  one-cycle pulse: HI/LO just written by MULT*/DIV*
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- mf_data  out  WIDTH  combinational: hi when funct==MFHI, lo when funct==MFLO, else 0

Behaviour:
- Reset (async, rst_n low): state=IDLE; hi=lo=0; busy=0; done=0; iteration counter=0.
- Reset asserted mid-operation aborts it; no partial HI/LO write survives.
- States:
  - IDLE
  - MUL: WIDTH iterations
  - DIV: WIDTH iterations
  - FIX: sign correction and HI/LO write
- Accept rule: start sampled only in IDLE. start while busy is ignored; no queueing, no error.
- start with any funct outside the eight listed codes is ignored.
- MTHI/MTLO (start, IDLE): hi (resp. lo) <= rs_val at that edge. No busy, no done.
- MFHI/MFLO: purely combinational read via mf_data, no state change.
  - Valid only when busy=0; stalling is the pipeline's job.
- MULT/MULTU/DIV/DIVU accepted at edge E0:
  - busy=1 from E0 through E32.
  - WIDTH=32 shift-add or restoring shift-subtract iterations on E1..E32. Counter wraps 31->0 and moves to FIX.
  - Edge E33: FIX writes hi/lo, state=IDLE, busy=0, done=1 for exactly one cycle.
  - Fixed latency: 33 cycles from accept to result, regardless of operand values. No early termination.
  - A new start is accepted on the same edge where done is raised? No: at E33 the state is still FIX, so the earliest next accept is E34.
- Signed handling (MULT, DIV):
  - Operate on magnitudes.
  - Product sign = signA XOR signB.
  - Quotient sign = signA XOR signB.
  - Remainder sign = sign of dividend.
  - Negation is two's complement at 2*WIDTH (product) or WIDTH (quotient/remainder).
- Multiply result: {hi,lo} = full 2*WIDTH product.
- Divide result: lo = quotient, hi = remainder.
- Divide by zero (rt_val==0, both DIV and DIVU):
  - Same 33-cycle latency.
  - lo = all ones; hi = rs_val unchanged.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Operand capture: rs_val/rt_val are registered at E0. Later changes on the inputs have no effect.

Decomposition:
- Shared header:
  - Add the MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO funct constants to the existing opcode header.
  - State encoding (2-bit) as localparams in this module, not shared.
- Datapath:
  - Single module.
  - Optional sub-module `muldiv_signfix`: combinational magnitude/negate helper used at E0 and in FIX.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy 33 cycles, done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then MULT with same operands -> hi=0, lo=1.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, latency still 33.
- Start MULT, then on the next cycle start DIV with new operands -> DIV ignored; MULT result correct. Start MTLO 0x1234 at E34 -> lo=0x1234 next cycle, no busy.
- Start DIVU, pull rst_n low at cycle 10 -> busy=0, hi=lo=0 immediately (async); after release, MFLO mf_data=0 and the unit accepts a new start.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared opcode header: R-type funct codes consumed by the execute-stage multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
    localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
    localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
    localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: magnitude extraction on accept, sign restore on writeback.
module muldiv_signfix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; fixed 33-cycle latency for MULT*/DIV*.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   rs_val,
    input  logic [WIDTH-1:0]   rt_val,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic [WIDTH-1:0]   mf_data
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    state_t             r_state, w_state_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic [ACC_W-1:0]   r_acc, w_acc_n;
    logic [WIDTH-1:0]   r_opd, w_opd_n;
    logic [WIDTH-1:0]   r_dividend, w_dividend_n;
    logic               r_neg_q, w_neg_q_n;
    logic               r_neg_r, w_neg_r_n;
    logic               r_is_div, w_is_div_n;
    logic               r_div_zero, w_div_zero_n;
    logic [WIDTH-1:0]   r_hi, w_hi_n;
    logic [WIDTH-1:0]   r_lo, w_lo_n;
    logic               r_busy, w_busy_n;
    logic               r_done, w_done_n;

    logic               w_is_signed, w_neg_a, w_neg_b;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [ACC_W-1:0]   w_mul_next;
    logic [WIDTH:0]     w_div_shift, w_div_diff;
    logic [ACC_W-1:0]   w_div_next;
    logic [ACC_W-1:0]   w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    assign w_is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign w_neg_a     = w_is_signed & rs_val[WIDTH-1];
    assign w_neg_b     = w_is_signed & rt_val[WIDTH-1];

    muldiv_signfix #(.W(WIDTH)) u_abs_a (.i_val(rs_val), .i_neg(w_neg_a), .o_val(w_abs_a));
    muldiv_signfix #(.W(WIDTH)) u_abs_b (.i_val(rt_val), .i_neg(w_neg_b), .o_val(w_abs_b));

    // Shift-add step: acc holds {partial product, remaining multiplier bits}
    assign w_mul_sum  = {1'b0, r_acc[ACC_W-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide step: acc holds {partial remainder, dividend/quotient bits}
    assign w_div_shift = {r_acc[ACC_W-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opd};
    assign w_div_next  = w_div_diff[WIDTH] ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                           : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    muldiv_signfix #(.W(ACC_W)) u_fix_p (.i_val(r_acc), .i_neg(r_neg_q), .o_val(w_prod));
    muldiv_signfix #(.W(WIDTH)) u_fix_q (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_q), .o_val(w_quo));
    muldiv_signfix #(.W(WIDTH)) u_fix_r (.i_val(r_acc[ACC_W-1:WIDTH]), .i_neg(r_neg_r), .o_val(w_rem));

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_acc_n      = r_acc;
        w_opd_n      = r_opd;
        w_dividend_n = r_dividend;
        w_neg_q_n    = r_neg_q;
        w_neg_r_n    = r_neg_r;
        w_is_div_n   = r_is_div;
        w_div_zero_n = r_div_zero;
        w_hi_n       = r_hi;
        w_lo_n       = r_lo;
        w_done_n     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (funct)
                        FUNCT_MTHI: w_hi_n = rs_val;
                        FUNCT_MTLO: w_lo_n = rs_val;
                        FUNCT_MULT, FUNCT_MULTU: begin
                            w_state_n  = ST_MUL;
                            w_cnt_n    = '0;
                            w_acc_n    = {{WIDTH{1'b0}}, w_abs_b};
                            w_opd_n    = w_abs_a;
                            w_neg_q_n  = w_neg_a ^ w_neg_b;
                            w_neg_r_n  = 1'b0;
                            w_is_div_n = 1'b0;
                        end
                        FUNCT_DIV, FUNCT_DIVU: begin
                            w_state_n    = ST_DIV;
                            w_cnt_n      = '0;
                            w_acc_n      = {{WIDTH{1'b0}}, w_abs_a};
                            w_opd_n      = w_abs_b;
                            w_neg_q_n    = w_neg_a ^ w_neg_b;
                            w_neg_r_n    = w_neg_a;
                            w_is_div_n   = 1'b1;
                            w_div_zero_n = (rt_val == '0);
                            w_dividend_n = rs_val;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                w_acc_n = (r_state == ST_MUL) ? w_mul_next : w_div_next;
                w_cnt_n = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_n = ST_FIX;
                end
            end
            ST_FIX: begin
                if (!r_is_div) begin
                    {w_hi_n, w_lo_n} = w_prod;
                end else if (r_div_zero) begin
                    w_hi_n = r_dividend;
                    w_lo_n = '1;
                end else begin
                    w_hi_n = w_rem;
                    w_lo_n = w_quo;
                end
                w_state_n = ST_IDLE;
                w_done_n  = 1'b1;
            end
            default: w_state_n = ST_IDLE;
        endcase

        w_busy_n = (w_state_n != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opd      <= '0;
            r_dividend <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_acc      <= w_acc_n;
            r_opd      <= w_opd_n;
            r_dividend <= w_dividend_n;
            r_neg_q    <= w_neg_q_n;
            r_neg_r    <= w_neg_r_n;
            r_is_div   <= w_is_div_n;
            r_div_zero <= w_div_zero_n;
            r_hi       <= w_hi_n;
            r_lo       <= w_lo_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign mf_data = (funct == FUNCT_MFHI) ? r_hi :
                     (funct == FUNCT_MFLO) ? r_lo : '0;

endmodule
